// File: rtl/decode_feed_ctrl.sv
// Fetch-bundle queue feeding the Divider: left-aligned head bundle with partial consume.
// Optional STALL_CNT_EN adds a saturating counter of cycles where valid slots are offered but none are taken.
module decode_feed_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [63:0]              fetch_bundle,
    input  logic [3:0]               fetch_mask,
    output logic                     fetch_ready,
    output logic [63:0]              div_inst_out,
    output logic [3:0]               div_slot_vld,
    input  logic [2:0]               take_cnt,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   r_data [DEPTH];
    logic [3:0]    r_mask [DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_hs;

    logic [AW-1:0] w_rd_ptr_nxt, w_wr_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [1:0]    w_hs_nxt;
    logic [63:0]   w_shift;
    logic [2:0]    w_avail, w_take;
    logic          w_enq, w_pop, w_adv, w_empty;

    assign fetch_ready = (r_count < FULL);
    assign occupancy   = r_count;
    assign w_empty     = (r_count == '0);

    // Head presentation: consumed slots shifted out, vacated and invalid slots read as NOP.
    always_comb begin
        w_shift      = r_data[r_rd_ptr] << {r_hs, 4'b0000};
        div_slot_vld = w_empty ? 4'b0000 : 4'(r_mask[r_rd_ptr] << r_hs);
        div_inst_out = {4{NOP_INST}};
        for (int s = 0; s < 4; s++) begin
            if (div_slot_vld[3-s]) div_inst_out[63-16*s -: 16] = w_shift[63-16*s -: 16];
        end
        w_avail = 3'(div_slot_vld[0]) + 3'(div_slot_vld[1])
                + 3'(div_slot_vld[2]) + 3'(div_slot_vld[3]);
    end

    // Next-state: flush dominates; over-large take is clamped to what is offered.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_hs_nxt     = r_hs;
        w_take       = (take_cnt > w_avail) ? w_avail : take_cnt;
        w_enq        = fetch_valid && fetch_ready && !flush && (fetch_mask != 4'b0000);
        w_pop        = !flush && (w_avail != 3'd0) && (w_take == w_avail);
        w_adv        = !flush && (w_take != 3'd0) && (w_take < w_avail);
        if (flush) begin
            w_rd_ptr_nxt = '0;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_hs_nxt     = '0;
        end else begin
            if (w_enq) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + AW'(1);
                w_hs_nxt     = '0;
            end else if (w_adv) begin
                w_hs_nxt = r_hs + 2'(w_take);
            end
            case ({w_enq, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_hs     <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            r_hs     <= w_hs_nxt;
        end
    end

    // Storage needs no reset: empty entries are never presented.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_data[r_wr_ptr] <= fetch_bundle;
            r_mask[r_wr_ptr] <= fetch_mask;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((div_slot_vld != 4'b0000) && (take_cnt == 3'd0) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_feed_ctrl.sv
// Directed vector bench for decode_feed_ctrl (DEPTH=4, NOP=0), plus reset and stall-counter sequences.
module tb_decode_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [63:0] fetch_bundle;
    logic [3:0]  fetch_mask;
    logic        fetch_ready;
    logic [63:0] div_inst_out;
    logic [3:0]  div_slot_vld;
    logic [2:0]  take_cnt;
    logic [2:0]  occupancy;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    decode_feed_ctrl #(.DEPTH(4), .NOP_INST(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
        .fetch_bundle(fetch_bundle), .fetch_mask(fetch_mask), .fetch_ready(fetch_ready),
        .div_inst_out(div_inst_out), .div_slot_vld(div_slot_vld), .take_cnt(take_cnt),
        .occupancy(occupancy)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        fv;
        logic [63:0] bundle;
        logic [3:0]  mask;
        logic [2:0]  take;
        logic        e_ready;
        logic [63:0] e_inst;
        logic [3:0]  e_vld;
        logic [2:0]  e_occ;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    localparam logic [63:0] B1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] B2 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] B3 = 64'h0102_0304_0506_0708;
    localparam logic [63:0] B4 = 64'h1010_2020_3030_4040;
    localparam logic [63:0] B5 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] B6 = 64'hDEAD_BEEF_0000_1111;

    function automatic vec_t mk(logic fl, logic fv, logic [63:0] b, logic [3:0] m, logic [2:0] t,
                                logic er, logic [63:0] ei, logic [3:0] ev, logic [2:0] eo);
        vec_t v;
        v.fl = fl; v.fv = fv; v.bundle = b; v.mask = m; v.take = t;
        v.e_ready = er; v.e_inst = ei; v.e_vld = ev; v.e_occ = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic er, input logic [63:0] ei,
                            input logic [3:0] ev, input logic [2:0] eo);
        chk({tag, ".fetch_ready"}, 64'(fetch_ready), 64'(er));
        chk({tag, ".div_inst_out"}, div_inst_out, ei);
        chk({tag, ".div_slot_vld"}, 64'(div_slot_vld), 64'(ev));
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(eo));
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [63:0] b,
                         input logic [3:0] m, input logic [2:0] t);
        flush = fl; fetch_valid = fv; fetch_bundle = b; fetch_mask = m; take_cnt = t;
    endtask

    initial begin
        //            fl fv bundle mask take | ready inst                    vld   occ
        vecs[0]  = mk(0, 1, B1, 4'hF, 3'd0,  1, B1,                      4'hF, 3'd1);
        vecs[1]  = mk(0, 0, B1, 4'hF, 3'd1,  1, 64'h2222_3333_4444_0000, 4'hE, 3'd1);
        vecs[2]  = mk(0, 0, B1, 4'hF, 3'd2,  1, 64'h4444_0000_0000_0000, 4'h8, 3'd1);
        vecs[3]  = mk(0, 0, B1, 4'hF, 3'd1,  1, 64'h0,                   4'h0, 3'd0);
        vecs[4]  = mk(0, 1, B2, 4'hF, 3'd0,  1, B2,                      4'hF, 3'd1);
        vecs[5]  = mk(0, 1, B3, 4'hC, 3'd0,  1, B2,                      4'hF, 3'd2);
        vecs[6]  = mk(0, 1, B4, 4'h8, 3'd0,  1, B2,                      4'hF, 3'd3);
        vecs[7]  = mk(0, 1, B5, 4'hE, 3'd0,  0, B2,                      4'hF, 3'd4);
        vecs[8]  = mk(0, 1, B6, 4'hF, 3'd0,  0, B2,                      4'hF, 3'd4);
        vecs[9]  = mk(0, 1, B6, 4'hF, 3'd4,  1, 64'h0102_0304_0000_0000, 4'hC, 3'd3);
        vecs[10] = mk(0, 1, B6, 4'hF, 3'd4,  1, 64'h1010_0000_0000_0000, 4'h8, 3'd3);
        vecs[11] = mk(0, 0, B6, 4'hF, 3'd1,  1, 64'h5555_6666_7777_0000, 4'hE, 3'd2);
        vecs[12] = mk(0, 0, B6, 4'hF, 3'd3,  1, B6,                      4'hF, 3'd1);
        vecs[13] = mk(0, 1, B2, 4'h0, 3'd0,  1, B6,                      4'hF, 3'd1);
        vecs[14] = mk(0, 0, B2, 4'h0, 3'd2,  1, 64'h0000_1111_0000_0000, 4'hC, 3'd1);
        vecs[15] = mk(0, 1, B1, 4'hF, 3'd0,  1, 64'h0000_1111_0000_0000, 4'hC, 3'd2);
        vecs[16] = mk(0, 1, B2, 4'hF, 3'd0,  1, 64'h0000_1111_0000_0000, 4'hC, 3'd3);
        vecs[17] = mk(1, 1, B3, 4'hC, 3'd4,  1, 64'h0,                   4'h0, 3'd0);
        vecs[18] = mk(0, 1, B1, 4'hF, 3'd0,  1, B1,                      4'hF, 3'd1);
        vecs[19] = mk(0, 1, B2, 4'hF, 3'd4,  1, B2,                      4'hF, 3'd1);
        vecs[20] = mk(0, 0, B2, 4'hF, 3'd7,  1, 64'h0,                   4'h0, 3'd0);

        rst_n = 1'b0;
        drive(0, 0, 64'h0, 4'h0, 3'd0);
        repeat (2) @(posedge clk);
        #1 chk_outs("reset", 1'b1, 64'h0, 4'h0, 3'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fl, vecs[i].fv, vecs[i].bundle, vecs[i].mask, vecs[i].take);
            @(posedge clk);
            #1 chk_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_inst,
                        vecs[i].e_vld, vecs[i].e_occ);
        end

        // Asynchronous reset mid-cycle with a populated queue.
        drive(0, 1, B3, 4'hC, 3'd0);
        @(posedge clk);
        #1 chk_outs("pre_arst", 1'b1, 64'h0102_0304_0000_0000, 4'hC, 3'd1);
        drive(0, 0, 64'h0, 4'h0, 3'd0);
        #2 rst_n = 1'b0;
        #1 chk_outs("arst", 1'b1, 64'h0, 4'h0, 3'd0);
`ifdef STALL_CNT_EN
        chk("arst.stall_cnt", 64'(stall_cnt), 64'h0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef STALL_CNT_EN
        drive(0, 1, B1, 4'hF, 3'd0);
        @(posedge clk);
        #1 drive(0, 0, 64'h0, 4'h0, 3'd0);
        chk("stall.start", 64'(stall_cnt), 64'h0);
        repeat (5) @(posedge clk);
        #1 chk("stall.five", 64'(stall_cnt), 64'd5);
        repeat (70000) @(posedge clk);
        #1 chk("stall.sat", 64'(stall_cnt), 64'hFFFF);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("stall.flush_keeps", 64'(stall_cnt), 64'hFFFF);
        chk("stall.flush_occ", 64'(occupancy), 64'd0);
        rst_n = 1'b0;
        #1 chk("stall.arst", 64'(stall_cnt), 64'h0);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_feed_ctrl.md
Name: decode_feed_ctrl

Overview:
- Buffers 64-bit fetch bundles (four 16-bit instructions, oldest in [63:48]) in a small circular queue.
- Presents the head bundle to the Divider's inst_in port each cycle, left-aligned with a per-slot valid mask.
- Decode/rename may consume 0-4 instructions per cycle. Unconsumed instructions of the head bundle are realigned to slot 0 for the next cycle.
- A flush empties everything for branch mispredict or exception recovery.

Parameters:
DEPTH, 4, number of bundle entries in the queue (power of 2, >=2)
NOP_INST, 16'h0000, encoding driven into empty or invalid slots

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous queue clear; highest priority
fetch_valid  in  1  fetch presents a bundle
fetch_bundle  in  64  {inst1,inst2,inst3,inst4}, inst1 oldest
fetch_mask  in  4  slot valid bits; bit3=inst1 ... bit0=inst4; must be contiguous from bit3
fetch_ready  out  1  queue can accept a bundle this cycle
div_inst_out  out  64  to Divider inst_in; head bundle left-aligned, invalid slots = NOP_INST
div_slot_vld  out  4  valid slots of div_inst_out, same bit order as fetch_mask
take_cnt  in  3  instructions consumed by decode this cycle, 0-4
occupancy  out  clog2(DEPTH)+1  number of bundles held

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read pointer, write pointer, count and head shift all go to 0.
  - Outputs: fetch_ready=1, div_slot_vld=0, div_inst_out={4{NOP_INST}}, occupancy=0.
- Queue:
  - Circular buffer of DEPTH entries; each entry holds a 64-bit bundle plus a 4-bit mask.
  - Pointers wrap modulo DEPTH.
  - fetch_ready = (count<DEPTH).
  - Enqueue when fetch_valid && fetch_ready && !flush && fetch_mask!=0.
  - A zero-mask bundle is accepted but discarded, with no count change.
- Output is combinational from the head entry and the head shift register hs (0-3 slots already consumed):
  - div_inst_out = head bundle shifted left by 16*hs, with vacated low slots = NOP_INST.
  - div_slot_vld = head mask shifted left by hs.
  - When empty: div_slot_vld=0 and all slots NOP_INST.
- Consume:
  - Let avail = popcount(div_slot_vld). The effective take is min(take_cnt, avail).
  - take_cnt > avail is a protocol error: the value is clamped and no state is corrupted.
  - If take == avail and avail>0: pop the entry (rd_ptr+1, hs<=0).
  - If 0 < take < avail: hs <= hs+take; the entry is kept.
  - take==0: no change.
- Latency:
  - A bundle enqueued at edge N appears on div_inst_out after edge N when the queue was empty.
  - There is no bypass from fetch_bundle to the output in the same cycle.
- Simultaneous events:
  - Enqueue and pop in the same cycle are both allowed, including when count==DEPTH. fetch_ready stays low that cycle, so no enqueue actually happens when full.
  - When count==1 and the head is popped while a new bundle enqueues, the new bundle becomes head next cycle with hs=0.
- flush: at the next edge pointers, count and hs clear; any same-cycle enqueue or take is ignored. Outputs read as empty from the following cycle.
- Reset asserted mid-operation discards all entries immediately; the output is empty while rst_n is low.
- count/occupancy updates by +1, -1, or 0. It is never out of range.

Optional Feature:
STALL_CNT_EN
- Defined:
  - Adds output stall_cnt[15:0].
  - Increments on every cycle with div_slot_vld!=0 and take_cnt==0; saturates at 16'hFFFF.
  - Cleared by rst_n only; flush does not clear it.
- Undefined: the port and counter are absent; the block is otherwise identical.

Test Plan:
- Reset then push bundle 64'h1111_2222_3333_4444, mask 4'hF, take 0 -> next cycle div_inst_out=64'h1111_2222_3333_4444, div_slot_vld=4'hF, occupancy=1.
- Same head, take_cnt=1 then take_cnt=2 -> div_inst_out=64'h2222_3333_4444_0000 (vld 4'hE), then 64'h4444_0000_0000_0000 (vld 4'h8). take_cnt=1 then pops: occupancy=0, vld=0.
- Push DEPTH=4 bundles with take 0 -> fetch_ready=0 and a fifth bundle is not stored. Take 4 with fetch_valid high -> pop and enqueue in later cycles preserve FIFO order across pointer wrap.
- Queue holding 3 bundles, flush=1 with fetch_valid=1 and take_cnt=4 -> next cycle occupancy=0, div_slot_vld=0, fetch_ready=1.
- Head mask 4'hC, take_cnt=4 -> clamped to 2, entry popped, next bundle presented intact.
- STALL_CNT_EN: hold a valid head with take 0 for 70000 cycles -> stall_cnt=16'hFFFF. Assert rst_n=0 mid-run -> all outputs return to reset values asynchronously.
